// File: rtl/mem_data_responder.sv
// Responder side of the MEM-stage data-memory port: one access at a time,
// a fixed number of wait states, then a commit with a one-cycle ready pulse.
module mem_data_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2,
  localparam int ADDR_W     = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [1:0]  in_load_mode,
  input  logic [31:0] in_address,
  input  logic [31:0] in_write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        busy,
  output logic        error
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  // The counter is loaded with one more than the wait-state count so that
  // even a zero-wait build spends one edge in S_WAIT before committing.
  localparam logic [4:0] WAIT_LOAD = 5'(WAIT_CYCLES + 1);

  state_t              state;
  logic [4:0]          wait_cnt;
  logic                is_read;
  logic                is_write;
  logic [1:0]          mode_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [31:0]         wdata_q;

  logic [31:0]         mem [DEPTH_WORDS];

  logic                is_word;
  logic                is_half;
  logic                misaligned;
  logic                acc_err;
  logic                commit;
  logic [ADDR_W-1:0]   word_idx;
  logic [31:0]         rd_word;
  logic [31:0]         rd_shift;
  logic [15:0]         rd_half;
  logic [31:0]         load_data;
  logic [3:0]          lane_en;
  logic [31:0]         lane_data;
  logic                addr_unused;

  // Address bits above the array are intentionally ignored (aliasing).
  assign addr_unused = ^in_address[31:ADDR_W+2];

  assign is_word    = (mode_q == 2'b00);
  assign is_half    = (mode_q == 2'b01);
  assign misaligned = (is_word && (addr_q[1:0] != 2'b00)) || (is_half && addr_q[0]);
  assign acc_err    = misaligned || (is_read && is_write);
  assign commit     = (state == S_WAIT) && (wait_cnt == 5'd1);
  assign word_idx   = addr_q[ADDR_W+1:2];
  assign rd_word    = mem[word_idx];
  assign rd_shift   = rd_word >> {addr_q[1:0], 3'b000};
  assign rd_half    = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    load_data = '0;
    lane_en   = 4'b0000;
    lane_data = wdata_q;
    case (mode_q)
      2'b00: begin
        load_data = rd_word;
        lane_en   = 4'b1111;
      end
      2'b01: begin
        load_data = {{16{rd_half[15]}}, rd_half};
        lane_en   = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
        lane_en   = 4'b0001 << addr_q[1:0];
        lane_data = {4{wdata_q[7:0]}};
      end
      default: begin
        load_data = {24'h0, rd_shift[7:0]};
        lane_en   = 4'b0001 << addr_q[1:0];
        lane_data = {4{wdata_q[7:0]}};
      end
    endcase
  end

  // NOTE: the array has no reset; contents survive rst_n and only the
  // control path is cleared, which also keeps it mappable onto RAM.
  always_ff @(posedge clk) begin
    if (commit && is_write && !acc_err) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_en[k]) mem[word_idx][8*k +: 8] <= lane_data[8*k +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      is_read   <= 1'b0;
      is_write  <= 1'b0;
      mode_q    <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      error     <= 1'b0;
      read_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          ready <= 1'b0;
          error <= 1'b0;
          if (in_mem_read || in_mem_write) begin
            is_read  <= in_mem_read;
            is_write <= in_mem_write;
            mode_q   <= in_load_mode;
            addr_q   <= in_address[ADDR_W+1:0];
            wdata_q  <= in_write_data;
            wait_cnt <= WAIT_LOAD;
            busy     <= 1'b1;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 5'd1) begin
            wait_cnt  <= '0;
            ready     <= 1'b1;
            error     <= acc_err;
            read_data <= (is_read && !acc_err) ? load_data : 32'h0;
            state     <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - 5'd1;
          end
        end
        S_RESP: begin
          ready <= 1'b0;
          busy  <= 1'b0;
          error <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_data_responder.sv
// Randomized and directed checks of mem_data_responder against a byte-array
// reference model; one instance with two wait states, one with none.
module tb_mem_data_responder;

  localparam int DEPTH = 256;
  localparam int NBYTES = DEPTH * 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic        rd_w2 = 1'b0, wr_w2 = 1'b0;
  logic [1:0]  mode_w2 = 2'b00;
  logic [31:0] addr_w2 = '0, wd_w2 = '0;
  logic [31:0] rdata_w2;
  logic        ready_w2, busy_w2, err_w2;

  logic        rd_w0 = 1'b0, wr_w0 = 1'b0;
  logic [1:0]  mode_w0 = 2'b00;
  logic [31:0] addr_w0 = '0, wd_w0 = '0;
  logic [31:0] rdata_w0;
  logic        ready_w0, busy_w0, err_w0;

  logic [7:0]  mdl [2][NBYTES];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_data_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n),
    .in_mem_read(rd_w2), .in_mem_write(wr_w2), .in_load_mode(mode_w2),
    .in_address(addr_w2), .in_write_data(wd_w2),
    .read_data(rdata_w2), .ready(ready_w2), .busy(busy_w2), .error(err_w2)
  );

  mem_data_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst_n(rst_n),
    .in_mem_read(rd_w0), .in_mem_write(wr_w0), .in_load_mode(mode_w0),
    .in_address(addr_w0), .in_write_data(wd_w0),
    .read_data(rdata_w0), .ready(ready_w0), .busy(busy_w0), .error(err_w0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wait_of(input int inst);
    return (inst == 0) ? 2 : 0;
  endfunction

  function automatic logic ready_of(input int inst);
    return (inst == 0) ? ready_w2 : ready_w0;
  endfunction

  function automatic logic busy_of(input int inst);
    return (inst == 0) ? busy_w2 : busy_w0;
  endfunction

  function automatic logic err_of(input int inst);
    return (inst == 0) ? err_w2 : err_w0;
  endfunction

  function automatic logic [31:0] data_of(input int inst);
    return (inst == 0) ? rdata_w2 : rdata_w0;
  endfunction

  task automatic drive(input int inst, input logic rd, input logic wr, input logic [1:0] mode,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (inst == 0) begin
      rd_w2 = rd; wr_w2 = wr; mode_w2 = mode; addr_w2 = addr; wd_w2 = wd;
    end else begin
      rd_w0 = rd; wr_w0 = wr; mode_w0 = mode; addr_w0 = addr; wd_w0 = wd;
    end
  endtask

  // Reference: memory as a flat little-endian byte array, access size from mode.
  task automatic model_op(input int inst, input logic rd, input logic wr, input logic [1:0] mode,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic err, output logic [31:0] data);
    int sz;
    int b;
    logic [31:0] raw;
    sz   = (mode == 2'b00) ? 4 : (mode == 2'b01) ? 2 : 1;
    b    = int'(addr % NBYTES);
    err  = (rd && wr) || ((addr % sz) != 0);
    data = 32'h0;
    raw  = 32'h0;
    if (!err && wr) begin
      for (int k = 0; k < sz; k++) mdl[inst][b + k] = wd[8*k +: 8];
    end
    if (!err && rd) begin
      for (int k = 0; k < sz; k++) raw = raw + (32'(mdl[inst][b + k]) << (8 * k));
      if (sz == 4) data = raw;
      else if (sz == 2) data = (raw >= 32'h8000) ? raw - 32'h10000 : raw;
      else if (mode == 2'b10) data = (raw >= 32'h80) ? raw - 32'h100 : raw;
      else data = raw;
    end
  endtask

  task automatic access(input int inst, input logic rd, input logic wr, input logic [1:0] mode,
                        input logic [31:0] addr, input logic [31:0] wd, output logic [31:0] obs);
    logic        exp_err;
    logic [31:0] exp_data;
    int          lat;
    model_op(inst, rd, wr, mode, addr, wd, exp_err, exp_data);
    obs = 32'hx;
    @(negedge clk);
    drive(inst, rd, wr, mode, addr, wd);
    @(posedge clk);
    #1;
    drive(inst, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    check("busy_after_accept", 32'(busy_of(inst)), 32'd1);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (ready_of(inst)) begin
        lat = i;
        break;
      end
    end
    check("latency", lat, wait_of(inst) + 1);
    if (lat != 0) begin
      obs = data_of(inst);
      check("resp_error", 32'(err_of(inst)), 32'(exp_err));
      check("resp_data", obs, exp_data);
      check("resp_busy", 32'(busy_of(inst)), 32'd1);
      @(posedge clk);
      #1;
      check("ready_pulse_end", 32'(ready_of(inst)), 32'd0);
      check("busy_end", 32'(busy_of(inst)), 32'd0);
    end
  endtask

  task automatic random_access(input int inst);
    logic [31:0] obs;
    logic [31:0] addr;
    int r;
    logic rd, wr;
    r    = $urandom_range(0, 9);
    rd   = (r == 0) || (r > 4);
    wr   = (r <= 4);
    addr = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
    access(inst, rd, wr, 2'($urandom_range(0, 3)), addr, $urandom, obs);
  endtask

  initial begin
    logic [31:0] obs;
    logic        exp_err;
    logic [31:0] exp_data;
    int          w;
    int          n_ready, first_rdy, second_rdy, busy_low;

    #1 rst_n = 1'b0;
    #2;
    check("rst_ready_w2", 32'(ready_w2), 32'd0);
    check("rst_busy_w2", 32'(busy_w2), 32'd0);
    check("rst_error_w2", 32'(err_w2), 32'd0);
    check("rst_data_w2", rdata_w2, 32'd0);
    check("rst_ready_w0", 32'(ready_w0), 32'd0);
    check("rst_busy_w0", 32'(busy_w0), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int inst = 0; inst < 2; inst++) begin
      for (int k = 0; k < 16; k++) access(inst, 1'b0, 1'b1, 2'b00, 32'(k * 4), $urandom, obs);
    end

    access(0, 1'b0, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF, obs);
    access(0, 1'b1, 1'b0, 2'b00, 32'h10, 32'h0, obs);
    check("tp_lw", obs, 32'hDEADBEEF);
    access(0, 1'b1, 1'b0, 2'b10, 32'h13, 32'h0, obs);
    check("tp_lb", obs, 32'hFFFFFFDE);
    access(0, 1'b1, 1'b0, 2'b11, 32'h13, 32'h0, obs);
    check("tp_lbu", obs, 32'h000000DE);
    access(0, 1'b1, 1'b0, 2'b01, 32'h10, 32'h0, obs);
    check("tp_lh", obs, 32'hFFFFBEEF);
    access(0, 1'b0, 1'b1, 2'b01, 32'h12, 32'h1234, obs);
    access(0, 1'b1, 1'b0, 2'b00, 32'h10, 32'h0, obs);
    check("tp_sh", obs, 32'h1234BEEF);
    access(0, 1'b0, 1'b1, 2'b10, 32'h11, 32'h55, obs);
    access(0, 1'b1, 1'b0, 2'b00, 32'h10, 32'h0, obs);
    check("tp_sb", obs, 32'h123455EF);
    access(0, 1'b1, 1'b0, 2'b00, 32'h12, 32'h0, obs);
    check("tp_mis_lw_data", obs, 32'h0);
    access(0, 1'b0, 1'b1, 2'b01, 32'h11, 32'hFFFF, obs);
    access(0, 1'b1, 1'b1, 2'b00, 32'h10, 32'h0, obs);
    check("tp_conflict_data", obs, 32'h0);
    access(0, 1'b1, 1'b0, 2'b00, 32'h10, 32'h0, obs);
    check("tp_unchanged", obs, 32'h123455EF);
    access(0, 1'b1, 1'b0, 2'b00, 32'hFFFF_FC10, 32'h0, obs);
    check("tp_alias", obs, 32'h123455EF);

    // Load held high through the response and the following idle cycle.
    w = wait_of(0);
    model_op(0, 1'b1, 1'b0, 2'b00, 32'h10, 32'h0, exp_err, exp_data);
    n_ready = 0; first_rdy = 0; second_rdy = 0; busy_low = 0;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 2'b00, 32'h10, 32'h0);
    @(posedge clk);
    for (int i = 1; i <= 2 * w + 6; i++) begin
      @(posedge clk);
      #1;
      if (ready_w2) begin
        n_ready++;
        check("held_data", rdata_w2, exp_data);
        if (n_ready == 1) first_rdy = i;
        else second_rdy = i;
      end
      if (!busy_w2 && i <= 2 * w + 4) busy_low++;
      if (i == w + 3) drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    end
    check("held_ready_count", n_ready, 2);
    check("held_first_ready", first_rdy, w + 1);
    check("held_second_ready", second_rdy, 2 * w + 4);
    check("held_busy_gaps", busy_low, 1);
    check("held_busy_final", 32'(busy_w2), 32'd0);

    // Reset during the wait states drops the uncommitted store.
    access(0, 1'b0, 1'b1, 2'b00, 32'h20, 32'h0BADF00D, obs);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 2'b00, 32'h20, 32'hAAAAAAAA);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(ready_w2), 32'd0);
    check("abort_busy", 32'(busy_w2), 32'd0);
    check("abort_error", 32'(err_w2), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    access(0, 1'b1, 1'b0, 2'b00, 32'h20, 32'h0, obs);
    check("abort_prior_value", obs, 32'h0BADF00D);

    access(1, 1'b0, 1'b1, 2'b00, 32'h10, 32'hCAFEF00D, obs);
    access(1, 1'b1, 1'b0, 2'b01, 32'h12, 32'h0, obs);
    check("w0_lh", obs, 32'hFFFFCAFE);

    for (int n = 0; n < 60; n++) random_access(0);
    for (int n = 0; n < 30; n++) random_access(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
